prio_encoder_rr: RTL and testbench

Parametrised, registered N-to-log2(N) encoder with a valid/ready handshake on both sides. It extends the team's 8-to-3 one-hot encoder in four ways: any input width, correct priority resolution for multi-hot inputs, a round-robin mode, and status flags and a counter for malformed (multi-hot or empty) request vectors. It sits between request sources, such as interrupt or channel-request lines, and a downstream consumer that may stall.

---
 rtl/prio_encoder_rr.sv | 116 +++++++++++
 tb/tb_prio_encoder_rr.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) request encoder with fixed-priority and round-robin
// modes, valid/ready handshake on both sides and a saturating multi-hot counter.
module prio_encoder_rr #(
  parameter  int unsigned N  = 8,
  parameter  int unsigned CW = 16,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  req,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] idx,
  output logic          multi,
  output logic          zero,
  output logic [CW-1:0] multi_cnt
);

  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          multi_q, multi_d;
  logic          zero_q, zero_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          req_zero;
  logic          req_multi;
  logic [AW-1:0] fix_idx;
  logic [AW-1:0] rr_idx;
  logic          rr_found;
  logic [AW-1:0] win_idx;

  assign in_ready  = !rst && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign req_zero  = ~|req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign req_multi = |(req & (req - N'(1)));

  // Fixed priority: ascending scan, so the highest set index is the last written.
  always_comb begin
    fix_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (req[k]) fix_idx = AW'(k);
    end
  end

  // Round-robin: scan ptr, ptr+1, ... with an explicit wrap at N (N need not be 2^AW).
  always_comb begin
    int unsigned pos;
    rr_idx   = '0;
    rr_found = 1'b0;
    pos      = 0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = {{(32-AW){1'b0}}, ptr_q} + off;
      if (pos >= N) pos = pos - N;
      if (!rr_found && req[pos]) begin
        rr_idx   = AW'(pos);
        rr_found = 1'b1;
      end
    end
  end

  assign win_idx = req_zero ? '0 : (mode ? rr_idx : fix_idx);

  always_comb begin
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    multi_d     = multi_q;
    zero_d      = zero_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      idx_d       = win_idx;
      multi_d     = req_multi;
      zero_d      = req_zero;
      if (mode && !req_zero) begin
        ptr_d = (win_idx == AW'(N-1)) ? '0 : win_idx + AW'(1);
      end
      if (req_multi && (cnt_q != '1)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      multi_q     <= 1'b0;
      zero_q      <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      multi_q     <= multi_d;
      zero_q      <= zero_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign multi     = multi_q;
  assign zero      = zero_q;
  assign multi_cnt = cnt_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: an N=8 instance for the main modes and
// an N=5, CW=2 instance for non-power-of-two wrap and counter saturation.
module tb_prio_encoder_rr;

  logic        clk;
  logic        rst;

  logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8, multi8, zero8;
  logic [7:0]  req8;
  logic [2:0]  idx8;
  logic [15:0] cnt8;

  logic        in_valid5, in_ready5, mode5, out_valid5, out_ready5, multi5, zero5;
  logic [4:0]  req5;
  logic [2:0]  idx5;
  logic [1:0]  cnt5;

  int unsigned n_cmp;
  int unsigned n_err;

  prio_encoder_rr #(.N(8), .CW(16)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .req(req8), .mode(mode8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .idx(idx8), .multi(multi8), .zero(zero8), .multi_cnt(cnt8)
  );

  prio_encoder_rr #(.N(5), .CW(2)) u_dut5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid5), .in_ready(in_ready5), .req(req5), .mode(mode5),
    .out_valid(out_valid5), .out_ready(out_ready5),
    .idx(idx5), .multi(multi5), .zero(zero5), .multi_cnt(cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] rr_exp [9];
    logic [2:0] skip_exp [3];
    n_cmp = 0;
    n_err = 0;

    // reset with an input presented: it must be ignored
    rst = 1'b1;
    in_valid8 = 1'b1; req8 = 8'hFF; mode8 = 1'b1; out_ready8 = 1'b1;
    in_valid5 = 1'b0; req5 = '0;    mode5 = 1'b1; out_ready5 = 1'b1;
    step();
    step();
    check("rst_in_ready", 32'(in_ready8), 32'd0);
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_idx", 32'(idx8), 32'd0);
    check("rst_multi", 32'(multi8), 32'd0);
    check("rst_zero", 32'(zero8), 32'd0);
    check("rst_cnt", 32'(cnt8), 32'd0);
    rst = 1'b0;
    #1;

    // one-hot sweep, fixed mode
    mode8 = 1'b0; in_valid8 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req8 = 8'(1 << k);
      #1;
      check($sformatf("sweep_in_ready%0d", k), 32'(in_ready8), 32'd1);
      step();
      check($sformatf("sweep_idx%0d", k), 32'(idx8), 32'(k));
      check($sformatf("sweep_valid%0d", k), 32'(out_valid8), 32'd1);
      check($sformatf("sweep_multi%0d", k), 32'(multi8), 32'd0);
      check($sformatf("sweep_zero%0d", k), 32'(zero8), 32'd0);
    end

    // fixed priority on multi-hot
    req8 = 8'hA5; step();
    check("fix_a5_idx", 32'(idx8), 32'd7);
    check("fix_a5_multi", 32'(multi8), 32'd1);
    check("fix_a5_cnt", 32'(cnt8), 32'd1);
    req8 = 8'h06; step();
    check("fix_06_idx", 32'(idx8), 32'd2);
    check("fix_06_cnt", 32'(cnt8), 32'd2);

    // reset while a result is pending
    rst = 1'b1; in_valid8 = 1'b0; step();
    check("midrst_valid", 32'(out_valid8), 32'd0);
    check("midrst_cnt", 32'(cnt8), 32'd0);
    rst = 1'b0;

    // round-robin wrap
    rr_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    mode8 = 1'b1; req8 = 8'hFF; in_valid8 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("rr_wrap%0d", i), 32'(idx8), 32'(rr_exp[i]));
    end

    // round-robin skip, from a fresh reset so ptr starts at 0
    rst = 1'b1; step(); rst = 1'b0;
    skip_exp = '{3'd1, 3'd5, 3'd1};
    req8 = 8'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rr_skip%0d", i), 32'(idx8), 32'(skip_exp[i]));
    end

    // empty request: zero flag, ptr stays at 2 so next 8'h22 picks 5
    req8 = 8'h00; step();
    check("empty_zero", 32'(zero8), 32'd1);
    check("empty_idx", 32'(idx8), 32'd0);
    check("empty_multi", 32'(multi8), 32'd0);
    req8 = 8'h22; step();
    check("empty_ptr_kept", 32'(idx8), 32'd5);
    check("empty_cnt", 32'(cnt8), 32'd4);

    // backpressure: a multi-hot input waits while the consumer stalls
    out_ready8 = 1'b0; mode8 = 1'b0; req8 = 8'h03;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready8), 32'd0);
      step();
      check($sformatf("bp_idx%0d", i), 32'(idx8), 32'd5);
      check($sformatf("bp_valid%0d", i), 32'(out_valid8), 32'd1);
      check($sformatf("bp_cnt%0d", i), 32'(cnt8), 32'd4);
    end
    out_ready8 = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready8), 32'd1);
    step();
    check("bp_release_idx", 32'(idx8), 32'd1);
    check("bp_release_valid", 32'(out_valid8), 32'd1);
    check("bp_release_cnt", 32'(cnt8), 32'd5);

    // drain: valid drops, payload held
    in_valid8 = 1'b0; step();
    check("drain_valid", 32'(out_valid8), 32'd0);
    check("drain_idx", 32'(idx8), 32'd1);
    check("drain_multi", 32'(multi8), 32'd1);

    // N=5 round-robin wrap and CW=2 saturation
    in_valid5 = 1'b1; req5 = 5'h1F; mode5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("n5_idx%0d", i), 32'(idx5), 32'(i % 5));
      check($sformatf("n5_cnt%0d", i), 32'(cnt5), 32'((i + 1 > 3) ? 3 : i + 1));
    end
    in_valid5 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
